// File: rtl/mic1_mem_ctrl_if.sv
// Single-port memory bus between the MIC-1 memory controller (master) and memory (slave).
interface mic1_mem_ctrl_if;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memRead;
    logic        memWrite;
    logic        memReady;

    modport master (
        output memAddr, memWData, memRead, memWrite,
        input  memReady, memRData
    );

    modport slave (
        input  memAddr, memWData, memRead, memWrite,
        output memReady, memRData
    );
endinterface

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory controller: turns rd/wr/fetch strobes into memory handshakes and MDR/MBR loads.
// Optional access timeout with memError pulse is enabled by defining MEM_TIMEOUT_EN.
module mic1_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd,
    input  logic                   wr,
    input  logic                   fetch,
    input  logic [31:0]            marIn,
    input  logic [31:0]            mdrIn,
    input  logic [31:0]            pcIn,
    mic1_mem_ctrl_if.master        mem,
    output logic [31:0]            mdrData,
    output logic                   mdrLoad,
    output logic [7:0]             mbrData,
    output logic                   mbrLoad,
    output logic                   busy,
    output logic                   memError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        FACC = 2'd2
    } ctrlState_t;

    ctrlState_t  state, nextState;
    logic        pendFetch, nextPend;
    logic        isWrite, nextIsWrite;
    logic [29:0] marReg;
    logic [31:0] mdrReg;
    logic [31:0] pcReg;
    logic        readReg, writeReg;
    logic        accept, done, abort, timeoutHit;

    // MAR's top two bits fall off the word-to-byte address shift.
    logic unusedBits;
    assign unusedBits = (^marIn[31:30]) ^ (TIMEOUT_CYCLES > 0);

    always_comb begin
        nextState   = state;
        nextPend    = pendFetch;
        nextIsWrite = isWrite;
        accept      = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd || wr) begin
                    nextState   = DACC;
                    accept      = 1'b1;
                    nextIsWrite = wr;
                    nextPend    = fetch;
                end else if (fetch) begin
                    nextState = FACC;
                    accept    = 1'b1;
                    nextPend  = 1'b0;
                end
            end
            DACC: begin
                if (mem.memReady) begin
                    done      = 1'b1;
                    nextState = pendFetch ? FACC : IDLE;
                end else if (timeoutHit) begin
                    abort = 1'b1;
                end
            end
            FACC: begin
                if (mem.memReady) begin
                    done      = 1'b1;
                    nextState = IDLE;
                    nextPend  = 1'b0;
                end else if (timeoutHit) begin
                    abort = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
        if (abort) begin
            nextState = IDLE;
            nextPend  = 1'b0;
        end
    end

    // Request lines are decoded from the next state so they rise with the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pendFetch <= 1'b0;
            isWrite   <= 1'b0;
            marReg    <= '0;
            mdrReg    <= '0;
            pcReg     <= '0;
            readReg   <= 1'b0;
            writeReg  <= 1'b0;
            mdrData   <= '0;
            mdrLoad   <= 1'b0;
            mbrData   <= '0;
            mbrLoad   <= 1'b0;
        end else begin
            state     <= nextState;
            pendFetch <= nextPend;
            isWrite   <= nextIsWrite;
            if (accept) begin
                marReg <= marIn[29:0];
                mdrReg <= mdrIn;
                pcReg  <= pcIn;
            end
            readReg  <= (nextState == FACC) || ((nextState == DACC) && !nextIsWrite);
            writeReg <= (nextState == DACC) && nextIsWrite;
            mdrLoad  <= done && (state == DACC) && !isWrite;
            if (done && (state == DACC) && !isWrite) begin
                mdrData <= mem.memRData;
            end
            mbrLoad <= done && (state == FACC);
            if (done && (state == FACC)) begin
                mbrData <= mem.memRData[{pcReg[1:0], 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        mem.memAddr  = '0;
        mem.memWData = '0;
        unique case (state)
            DACC: begin
                mem.memAddr  = {marReg, 2'b00};
                mem.memWData = isWrite ? mdrReg : 32'd0;
            end
            FACC:    mem.memAddr = {pcReg[31:2], 2'b00};
            default: mem.memAddr = '0;
        endcase
    end

    assign mem.memRead  = readReg;
    assign mem.memWrite = writeReg;
    assign busy         = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] timer;

    assign timeoutHit = (state != IDLE) && (timer == TW'(TIMEOUT_CYCLES));

    // Counter restarts whenever a new state is entered, so a fetch after a read gets a full budget.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer    <= '0;
            memError <= 1'b0;
        end else begin
            memError <= abort;
            if ((state == IDLE) || (nextState != state)) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign memError   = 1'b0;
`endif

endmodule
